// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD SPI receiver.
package lcd_pkg;

    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int DEF_H_PIXELS = 160;
    localparam int DEF_V_PIXELS = 80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PIX_HI = 2'd1,
        PIX_LO = 2'd2
    } lcd_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bank with a per-bit idle level applied on reset.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lcd_spi_rx.sv
// Receives a SPI-style LCD bus, emits bytes and assembles RGB565 pixels
// with raster coordinates after a RAMWR command.
module lcd_spi_rx
    import lcd_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_PIXELS = DEF_V_PIXELS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_clk,
    input  logic        lcd_data,
    input  logic        lcd_cs,
    input  logic        lcd_rs,
    input  logic        lcd_resetn,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_is_data,
    output logic        pixel_valid,
    output logic [15:0] pixel_rgb,
    output logic [7:0]  pixel_x,
    output logic [7:0]  pixel_y,
    output logic        frame_done,
    output logic        frame_error
);

    localparam logic [7:0] X_LAST    = 8'(H_PIXELS - 1);
    localparam logic [7:0] Y_LAST    = 8'(V_PIXELS - 1);
    // Idle levels in {resetn, rs, cs, data, clk} order
    localparam logic [4:0] SYNC_IDLE = 5'b10100;

    logic [4:0] bus_sync;
    logic       s_clk, s_data, s_cs, s_rs, s_resetn;
    logic       clk_d, cs_d;
    logic       clk_rise, cs_rise;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic [7:0] rx_byte;
    logic [7:0] hi_byte;
    logic [7:0] x, y;
    lcd_state_t state;

    sync_2ff #(
        .WIDTH     (5),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({lcd_resetn, lcd_rs, lcd_cs, lcd_data, lcd_clk}),
        .q   (bus_sync)
    );

    assign {s_resetn, s_rs, s_cs, s_data, s_clk} = bus_sync;
    assign clk_rise = s_clk & ~clk_d;
    assign cs_rise  = s_cs & ~cs_d;
    assign rx_byte  = {shift_reg, s_data};

    // Panel reset outranks byte completion, which outranks a cs abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_d        <= 1'b0;
            cs_d         <= 1'b1;
            bit_cnt      <= 3'd0;
            shift_reg    <= 7'd0;
            hi_byte      <= 8'd0;
            x            <= 8'd0;
            y            <= 8'd0;
            state        <= IDLE;
            byte_valid   <= 1'b0;
            byte_data    <= 8'd0;
            byte_is_data <= 1'b0;
            pixel_valid  <= 1'b0;
            pixel_rgb    <= 16'd0;
            pixel_x      <= 8'd0;
            pixel_y      <= 8'd0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            clk_d       <= s_clk;
            cs_d        <= s_cs;
            byte_valid  <= 1'b0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (!s_resetn) begin
                bit_cnt     <= 3'd0;
                shift_reg   <= 7'd0;
                state       <= IDLE;
                x           <= 8'd0;
                y           <= 8'd0;
                frame_error <= 1'b0;
            end else if (clk_rise && !s_cs) begin
                shift_reg <= rx_byte[6:0];
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid   <= 1'b1;
                    byte_data    <= rx_byte;
                    byte_is_data <= s_rs;
                    if (!s_rs) begin
                        if (rx_byte == CMD_RAMWR) begin
                            state <= PIX_HI;
                            x     <= 8'd0;
                            y     <= 8'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        case (state)
                            PIX_HI: begin
                                hi_byte <= rx_byte;
                                state   <= PIX_LO;
                            end
                            PIX_LO: begin
                                pixel_valid <= 1'b1;
                                pixel_rgb   <= {hi_byte, rx_byte};
                                pixel_x     <= x;
                                pixel_y     <= y;
                                state       <= PIX_HI;
                                if (x == X_LAST) begin
                                    x <= 8'd0;
                                    if (y == Y_LAST) begin
                                        y          <= 8'd0;
                                        frame_done <= 1'b1;
                                    end else begin
                                        y <= y + 8'd1;
                                    end
                                end else begin
                                    x <= x + 8'd1;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            end else if (cs_rise && bit_cnt != 3'd0) begin
                bit_cnt     <= 3'd0;
                frame_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed self-checking bench for lcd_spi_rx using a 4x2 frame.
module tb_lcd_spi_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lcd_clk = 1'b0;
    logic        lcd_data = 1'b0;
    logic        lcd_cs = 1'b1;
    logic        lcd_rs = 1'b0;
    logic        lcd_resetn = 1'b1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_is_data;
    logic        pixel_valid;
    logic [15:0] pixel_rgb;
    logic [7:0]  pixel_x;
    logic [7:0]  pixel_y;
    logic        frame_done;
    logic        frame_error;

    int errors = 0;
    int checks = 0;

    int          n_bytes = 0;
    int          n_pix = 0;
    int          n_frames = 0;
    int          n_wide = 0;
    logic        prev_bv = 1'b0;
    logic [7:0]  last_byte = 8'd0;
    logic        last_is_data = 1'b0;
    logic [15:0] rec_rgb [64];
    logic [7:0]  rec_x [64];
    logic [7:0]  rec_y [64];
    logic        rec_fd [64];

    lcd_spi_rx #(
        .H_PIXELS (4),
        .V_PIXELS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_clk      (lcd_clk),
        .lcd_data     (lcd_data),
        .lcd_cs       (lcd_cs),
        .lcd_rs       (lcd_rs),
        .lcd_resetn   (lcd_resetn),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data),
        .pixel_valid  (pixel_valid),
        .pixel_rgb    (pixel_rgb),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .frame_done   (frame_done),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    // Record every strobe seen on the outputs, sampled away from the active edge
    always @(negedge clk) begin
        if (byte_valid) begin
            n_bytes++;
            last_byte    = byte_data;
            last_is_data = byte_is_data;
        end
        if (byte_valid && prev_bv) n_wide++;
        prev_bv = byte_valid;
        if (pixel_valid && n_pix < 64) begin
            rec_rgb[n_pix] = pixel_rgb;
            rec_x[n_pix]   = pixel_x;
            rec_y[n_pix]   = pixel_y;
            rec_fd[n_pix]  = frame_done;
            n_pix++;
        end
        if (frame_done) n_frames++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pixel(input int idx, input logic [15:0] rgb,
                               input logic [7:0] px, input logic [7:0] py, input logic fd);
        check_output($sformatf("pix%0d_rgb", idx), 32'(rec_rgb[idx]), 32'(rgb));
        check_output($sformatf("pix%0d_x", idx), 32'(rec_x[idx]), 32'(px));
        check_output($sformatf("pix%0d_y", idx), 32'(rec_y[idx]), 32'(py));
        check_output($sformatf("pix%0d_fd", idx), 32'(rec_fd[idx]), 32'(fd));
    endtask

    // lcd_clk runs at clk/8: 4 clk low, 4 clk high per bit, MSB first
    task automatic apply_bits(input logic rs, input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            lcd_data = b[i];
            lcd_rs   = rs;
            lcd_clk  = 1'b0;
            wait_clk(4);
            lcd_clk  = 1'b1;
            wait_clk(4);
        end
        lcd_clk = 1'b0;
    endtask

    task automatic apply_byte(input logic rs, input logic [7:0] b);
        lcd_cs = 1'b0;
        apply_bits(rs, b, 8);
    endtask

    initial begin
        int base_bytes;

        // Reset state
        wait_clk(3);
        check_output("rst_byte_valid", 32'(byte_valid), 32'd0);
        check_output("rst_byte_data", 32'(byte_data), 32'd0);
        check_output("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check_output("rst_pixel_rgb", 32'(pixel_rgb), 32'd0);
        check_output("rst_frame_error", 32'(frame_error), 32'd0);
        rst = 1'b1;
        wait_clk(3);

        // Command byte
        apply_byte(1'b0, 8'h2C);
        wait_clk(2);
        check_output("cmd_count", 32'(n_bytes), 32'd1);
        check_output("cmd_data", 32'(byte_data), 32'h2C);
        check_output("cmd_is_data", 32'(byte_is_data), 32'd0);
        check_output("cmd_no_pixel", 32'(n_pix), 32'd0);

        // First two pixels
        apply_byte(1'b1, 8'hF8);
        apply_byte(1'b1, 8'h00);
        apply_byte(1'b1, 8'h07);
        apply_byte(1'b1, 8'hE0);
        wait_clk(2);
        check_output("px_count", 32'(n_pix), 32'd2);
        check_output("px_is_data", 32'(byte_is_data), 32'd1);
        check_pixel(0, 16'hF800, 8'd0, 8'd0, 1'b0);
        check_pixel(1, 16'h07E0, 8'd1, 8'd0, 1'b0);

        // Full 4x2 frame, then a clean deselect, then the first pixel of the next frame
        apply_byte(1'b0, 8'h2C);
        for (int i = 0; i < 8; i++) begin
            apply_byte(1'b1, 8'(i));
            apply_byte(1'b1, 8'(8'h10 + i));
        end
        wait_clk(2);
        check_output("frame_count", 32'(n_frames), 32'd1);
        check_output("frame_pix_count", 32'(n_pix), 32'd10);
        for (int i = 0; i < 8; i++)
            check_pixel(2 + i, {8'(i), 8'(8'h10 + i)}, 8'(i % 4), 8'(i / 4), (i == 7));
        lcd_cs = 1'b1;
        wait_clk(8);
        check_output("clean_deselect_err", 32'(frame_error), 32'd0);
        apply_byte(1'b1, 8'hBE);
        apply_byte(1'b1, 8'hEF);
        wait_clk(2);
        check_output("wrap_pix_count", 32'(n_pix), 32'd11);
        check_pixel(10, 16'hBEEF, 8'd0, 8'd0, 1'b0);

        // Aborted byte after 5 bits
        base_bytes = n_bytes;
        apply_bits(1'b1, 8'hFF, 5);
        lcd_cs = 1'b1;
        wait_clk(6);
        check_output("abort_no_byte", 32'(n_bytes), 32'(base_bytes));
        check_output("abort_err_set", 32'(frame_error), 32'd1);
        apply_byte(1'b1, 8'hA5);
        wait_clk(2);
        check_output("after_abort_count", 32'(n_bytes), 32'(base_bytes + 1));
        check_output("after_abort_data", 32'(byte_data), 32'hA5);
        check_output("after_abort_is_data", 32'(byte_is_data), 32'd1);
        check_output("err_sticky", 32'(frame_error), 32'd1);
        lcd_resetn = 1'b0;
        wait_clk(6);
        check_output("panel_rst_err_clr", 32'(frame_error), 32'd0);
        lcd_resetn = 1'b1;
        wait_clk(4);

        // Dropped high byte: command 0x00 returns to IDLE
        base_bytes = n_bytes;
        apply_byte(1'b0, 8'h2C);
        apply_byte(1'b1, 8'h12);
        apply_byte(1'b0, 8'h00);
        apply_byte(1'b1, 8'h34);
        wait_clk(2);
        check_output("drop_byte_data", 32'(last_byte), 32'h34);
        apply_byte(1'b1, 8'h56);
        wait_clk(2);
        check_output("drop_byte_count", 32'(n_bytes), 32'(base_bytes + 5));
        check_output("drop_no_pixel", 32'(n_pix), 32'd11);
        check_output("drop_last_data", 32'(last_is_data), 32'd1);

        // Reset after the high byte and partway through the next byte
        apply_byte(1'b0, 8'h2C);
        apply_byte(1'b1, 8'h11);
        apply_bits(1'b1, 8'h22, 3);
        rst = 1'b0;
        wait_clk(3);
        check_output("mid_rst_byte_data", 32'(byte_data), 32'd0);
        check_output("mid_rst_pixel_rgb", 32'(pixel_rgb), 32'd0);
        check_output("mid_rst_pixel_x", 32'(pixel_x), 32'd0);
        rst = 1'b1;
        wait_clk(4);
        apply_byte(1'b0, 8'h2C);
        apply_byte(1'b1, 8'hAB);
        apply_byte(1'b1, 8'hCD);
        wait_clk(2);
        check_output("post_rst_pix_count", 32'(n_pix), 32'd12);
        check_pixel(11, 16'hABCD, 8'd0, 8'd0, 1'b0);

        check_output("strobe_width", 32'(n_wide), 32'd0);
        check_output("total_frames", 32'(n_frames), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
